// File: rtl/spi_io_pkg.sv
// Shared types and register map for the memory-mapped SPI master.
package spi_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_t;

    localparam logic [1:0] SPI_CTRL   = 2'd0;
    localparam logic [1:0] SPI_DIV    = 2'd1;
    localparam logic [1:0] SPI_DATA   = 2'd2;
    localparam logic [1:0] SPI_STATUS = 2'd3;

    localparam int CTRL_CPHA   = 0;
    localparam int CTRL_CPOL   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_DEV    = 8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every div+1 clocks, reloaded on restart.
module spi_clk_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/spi_io_master.sv
// Register-mapped SPI master: CTRL/DIV/DATA/STATUS, all four SPI modes, encoded device select.
module spi_io_master
    import spi_io_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int XFER_WIDTH = 8,
    parameter int SS_BITS    = 3,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sel_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic [1:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  irq_o,
    output logic                  spi_clk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [SS_BITS-1:0]    spi_addr
);

    localparam int BCNT_W = $clog2(XFER_WIDTH + 1);

    spi_state_t state, state_next;

    logic                  cpha, cpol, irq_en;
    logic [SS_BITS-1:0]    dev;
    logic [DIV_WIDTH-1:0]  div;
    logic                  busy, done, overrun;
    logic [XFER_WIDTH-1:0] rx, tx_sr, rx_sr, tx_shift;
    logic [XFER_WIDTH:0]   rx_cat;
    logic [BCNT_W-1:0]     bit_cnt;
    logic                  tick, idle, start, leading, last_edge, shift_tx, sample_rx;
    logic                  wr_ctrl, wr_div, wr_data, wr_stat, rd_data;
    logic [DATA_WIDTH-1:0] ctrl_word, stat_word, read_word;
    logic                  unused_bits;

    assign wr_ctrl = sel_i && wr_i && (addr_i == SPI_CTRL);
    assign wr_div  = sel_i && wr_i && (addr_i == SPI_DIV);
    assign wr_data = sel_i && wr_i && (addr_i == SPI_DATA);
    assign wr_stat = sel_i && wr_i && (addr_i == SPI_STATUS);
    assign rd_data = sel_i && rd_i && (addr_i == SPI_DATA);

    assign idle  = (state == IDLE);
    assign start = wr_data && idle;

    // Leading edge = spi_clk leaving its idle level; the final trailing edge ends SHIFT.
    assign leading   = (spi_clk == cpol);
    assign last_edge = !leading &&
                       (bit_cnt == (cpha ? BCNT_W'(XFER_WIDTH - 1) : BCNT_W'(XFER_WIDTH)));
    assign sample_rx = (state == SHIFT) && tick && (leading != cpha);
    assign shift_tx  = (state == SHIFT) && tick &&
                       (cpha ? (leading && bit_cnt != '0) : (!leading && !last_edge));
    assign tx_shift  = tx_sr << 1;
    assign rx_cat    = {rx_sr, miso};
    assign irq_o     = done && irq_en;
    assign unused_bits = ^{wd_i, rx_cat[XFER_WIDTH]};

    spi_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_clk_div (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .restart (start),
        .div     (div),
        .tick    (tick)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (tick && last_edge) state_next = HOLD;
            HOLD:    if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_CPHA]   = cpha;
        ctrl_word[CTRL_CPOL]   = cpol;
        ctrl_word[CTRL_IRQ_EN] = irq_en;
        ctrl_word[CTRL_DEV +: SS_BITS] = dev;
        stat_word = '0;
        stat_word[STAT_BUSY]    = busy;
        stat_word[STAT_DONE]    = done;
        stat_word[STAT_OVERRUN] = overrun;
        read_word = stat_word;
        case (addr_i)
            SPI_CTRL: read_word = ctrl_word;
            SPI_DIV:  read_word = DATA_WIDTH'(div);
            SPI_DATA: read_word = DATA_WIDTH'(rx);
            default:  read_word = stat_word;
        endcase
    end

    // Shift registers carry data only and are always loaded before use.
    always_ff @(posedge clk_i) begin
        if (start) begin
            tx_sr   <= wd_i[XFER_WIDTH-1:0];
            bit_cnt <= '0;
        end else begin
            if (shift_tx) tx_sr <= tx_shift;
            if (sample_rx) begin
                rx_sr   <= rx_cat[XFER_WIDTH-1:0];
                bit_cnt <= bit_cnt + BCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cpha     <= 1'b0;
            cpol     <= 1'b0;
            irq_en   <= 1'b0;
            dev      <= '0;
            div      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            rx       <= '0;
            rd_o     <= '0;
            spi_clk  <= 1'b0;
            mosi     <= 1'b0;
            spi_addr <= '0;
        end else begin
            if (idle && wr_ctrl) begin
                cpha   <= wd_i[CTRL_CPHA];
                cpol   <= wd_i[CTRL_CPOL];
                irq_en <= wd_i[CTRL_IRQ_EN];
                dev    <= wd_i[CTRL_DEV +: SS_BITS];
            end
            if (idle && wr_div) div <= wd_i[DIV_WIDTH-1:0];
            if (shift_tx) mosi <= tx_shift[XFER_WIDTH-1];
            case (state)
                IDLE: begin
                    spi_clk <= wr_ctrl ? wd_i[CTRL_CPOL] : cpol;
                    if (start) begin
                        busy     <= 1'b1;
                        spi_addr <= dev;
                        mosi     <= wd_i[XFER_WIDTH-1];
                    end
                end
                SHIFT: if (tick) spi_clk <= ~spi_clk;
                HOLD:  if (tick) spi_addr <= '0;
                DONE: begin
                    busy <= 1'b0;
                    rx   <= rx_sr;
                end
                default: ;
            endcase
            // Setting a flag takes priority over a simultaneous clear.
            if (state == DONE) done <= 1'b1;
            else if (rd_data || (wr_stat && wd_i[STAT_DONE])) done <= 1'b0;
            if (wr_data && !idle) overrun <= 1'b1;
            else if (wr_stat && wd_i[STAT_OVERRUN]) overrun <= 1'b0;
            if (sel_i && rd_i) rd_o <= read_word;
        end
    end

endmodule

// File: tb/tb_spi_io_master.sv
// Directed bench: 8-bit/3-select instance and a 16-bit/2-select instance with slave models.
module tb_spi_io_master;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        sel1 = 1'b0, sel2 = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd_o1, rd_o2;
    logic        irq1, irq2, spi_clk1, spi_clk2, mosi1, mosi2, miso1, miso2;
    logic [2:0]  spi_addr1;
    logic [1:0]  spi_addr2;

    logic        use_loop = 1'b0;
    logic [7:0]  word1 = 8'd0;
    logic [15:0] word2 = 16'd0;
    logic        idle1, idle2, sbit1, sbit2;
    int          fc1, fc2, rises1, low1, falls2;
    logic [7:0]  bits1;
    logic [15:0] cap2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_io_master u_dut1 (
        .clk_i(clk), .reset_i(reset_i), .sel_i(sel1), .wr_i(wr), .rd_i(rd),
        .addr_i(addr), .wd_i(wd), .rd_o(rd_o1), .irq_o(irq1),
        .spi_clk(spi_clk1), .mosi(mosi1), .miso(miso1), .spi_addr(spi_addr1)
    );

    spi_io_master #(.DATA_WIDTH(32), .XFER_WIDTH(16), .SS_BITS(2), .DIV_WIDTH(8)) u_dut2 (
        .clk_i(clk), .reset_i(reset_i), .sel_i(sel2), .wr_i(wr), .rd_i(rd),
        .addr_i(addr), .wd_i(wd), .rd_o(rd_o2), .irq_o(irq2),
        .spi_clk(spi_clk2), .mosi(mosi2), .miso(miso2), .spi_addr(spi_addr2)
    );

    // CPHA=1 slaves: present the next bit after each falling spi_clk edge.
    assign idle1 = (spi_addr1 == 3'd0);
    assign idle2 = (spi_addr2 == 2'd0);
    always @(negedge spi_clk1, posedge idle1) if (idle1) fc1 <= 0; else fc1 <= fc1 + 1;
    always @(negedge spi_clk2, posedge idle2) if (idle2) fc2 <= 0; else fc2 <= fc2 + 1;
    always_comb sbit1 = (fc1 >= 1 && fc1 <= 8) ? word1[3'(8 - fc1)] : 1'b0;
    always_comb sbit2 = (fc2 >= 1 && fc2 <= 16) ? word2[4'(16 - fc2)] : 1'b0;
    assign miso1 = use_loop ? mosi1 : sbit1;
    assign miso2 = sbit2;

    always @(posedge spi_clk1) if (!idle1) begin
        rises1 <= rises1 + 1;
        bits1  <= {bits1[6:0], mosi1};
    end
    always @(posedge clk) if (!idle1 && !spi_clk1) low1 <= low1 + 1;
    always @(posedge spi_clk2) if (!idle2) cap2 <= {cap2[14:0], mosi2};
    always @(negedge spi_clk2) if (!idle2) falls2 <= falls2 + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wreg(input int which, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel1 = (which == 1); sel2 = (which == 2); wr = 1'b1; addr = a; wd = d;
        @(posedge clk); #1;
        sel1 = 1'b0; sel2 = 1'b0; wr = 1'b0;
    endtask

    task automatic rreg(input int which, input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel1 = (which == 1); sel2 = (which == 2); rd = 1'b1; addr = a;
        @(posedge clk); #1;
        d = (which == 1) ? rd_o1 : rd_o2;
        sel1 = 1'b0; sel2 = 1'b0; rd = 1'b0;
    endtask

    // Called right after the DATA write edge; n = cycles until STATUS.busy reads back low.
    task automatic poll(input int which, output int n);
        logic b;
        sel1 = (which == 1); sel2 = (which == 2); rd = 1'b1; addr = 2'd3;
        n = 999;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            b = (which == 1) ? rd_o1[0] : rd_o2[0];
            if (!b) begin
                n = i + 1;
                break;
            end
        end
        sel1 = 1'b0; sel2 = 1'b0; rd = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int n, base, lbase;

        repeat (3) @(posedge clk);
        #1;
        check("rst_spi_clk", 64'(spi_clk1), 64'(0));
        check("rst_mosi", 64'(mosi1), 64'(0));
        check("rst_spi_addr", 64'(spi_addr1), 64'(0));
        check("rst_irq", 64'(irq1), 64'(0));
        check("rst_rd_o", 64'(rd_o1), 64'(0));
        @(negedge clk) reset_i = 1'b0;
        rreg(1, 2'd3, r);
        check("rst_status", 64'(r), 64'(0));

        // Mode 0, DIV=0, dev 3, loopback
        use_loop = 1'b1;
        wreg(1, 2'd0, 32'h0000_0300);
        wreg(1, 2'd1, 32'h0);
        base = rises1;
        wreg(1, 2'd2, 32'h0000_00A5);
        check("m0_spi_addr", 64'(spi_addr1), 64'(3));
        check("m0_mosi_msb", 64'(mosi1), 64'(1));
        poll(1, n);
        check("m0_cycles", 64'(n), 64'(20));
        check("m0_rises", 64'(rises1 - base), 64'(8));
        check("m0_mosi_bits", 64'(bits1), 64'(8'hA5));
        check("m0_addr_released", 64'(spi_addr1), 64'(0));
        rreg(1, 2'd3, r);
        check("m0_status_done", 64'(r), 64'(2));
        rreg(1, 2'd2, r);
        check("m0_rx", 64'(r), 64'(8'hA5));
        rreg(1, 2'd3, r);
        check("m0_done_cleared", 64'(r), 64'(0));

        // Mode 3, DIV=2, dev 1, irq enabled, slave sends 0x3C
        use_loop = 1'b0;
        word1 = 8'h3C;
        wreg(1, 2'd1, 32'h2);
        wreg(1, 2'd0, 32'h0000_0107);
        check("m3_cpol_idle", 64'(spi_clk1), 64'(1));
        lbase = low1;
        wreg(1, 2'd2, 32'h0000_0081);
        check("m3_irq_low", 64'(irq1), 64'(0));
        poll(1, n);
        check("m3_cycles", 64'(n), 64'(56));
        check("m3_low_clks", 64'(low1 - lbase), 64'(24));
        check("m3_irq_high", 64'(irq1), 64'(1));
        rreg(1, 2'd2, r);
        check("m3_rx", 64'(r), 64'(8'h3C));
        check("m3_irq_cleared", 64'(irq1), 64'(0));

        // Overrun: second DATA write and a CTRL write mid-transfer are ignored
        word1 = 8'h96;
        wreg(1, 2'd2, 32'h0000_0055);
        repeat (10) @(posedge clk);
        wreg(1, 2'd2, 32'h0000_00FF);
        wreg(1, 2'd0, 32'h0);
        rreg(1, 2'd3, r);
        check("ovr_status_busy", 64'(r), 64'(5));
        poll(1, n);
        rreg(1, 2'd3, r);
        check("ovr_status_end", 64'(r), 64'(6));
        rreg(1, 2'd0, r);
        check("ovr_ctrl_kept", 64'(r), 64'(32'h107));
        wreg(1, 2'd3, 32'h4);
        rreg(1, 2'd3, r);
        check("ovr_cleared", 64'(r), 64'(2));
        rreg(1, 2'd2, r);
        check("ovr_rx", 64'(r), 64'(8'h96));
        rreg(1, 2'd3, r);
        check("ovr_status_zero", 64'(r), 64'(0));

        // Reset at bit 4 aborts the transfer
        base = rises1;
        wreg(1, 2'd2, 32'h0000_00C3);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (rises1 - base >= 4) break;
        end
        check("abort_reached_bit4", 64'(rises1 - base), 64'(4));
        @(negedge clk) reset_i = 1'b1;
        @(posedge clk); #1;
        check("abort_spi_addr", 64'(spi_addr1), 64'(0));
        check("abort_spi_clk", 64'(spi_clk1), 64'(0));
        @(negedge clk) reset_i = 1'b0;
        rreg(1, 2'd3, r);
        check("abort_status", 64'(r), 64'(0));

        // Fresh transfer after abort: mode 0, DIV=1, dev 5
        use_loop = 1'b1;
        wreg(1, 2'd0, 32'h0000_0500);
        wreg(1, 2'd1, 32'h1);
        wreg(1, 2'd2, 32'h0000_005A);
        check("post_spi_addr", 64'(spi_addr1), 64'(5));
        poll(1, n);
        check("post_cycles", 64'(n), 64'(38));
        rreg(1, 2'd2, r);
        check("post_rx", 64'(r), 64'(8'h5A));

        // 16-bit instance, mode 3, DIV=0, dev 2
        word2 = 16'hBEEF;
        wreg(2, 2'd0, 32'h0000_0203);
        base = falls2;
        wreg(2, 2'd2, 32'h0000_1234);
        check("w16_spi_addr", 64'(spi_addr2), 64'(2));
        poll(2, n);
        check("w16_cycles", 64'(n), 64'(36));
        check("w16_falls", 64'(falls2 - base), 64'(16));
        check("w16_mosi_word", 64'(cap2), 64'(16'h1234));
        rreg(2, 2'd2, r);
        check("w16_rx", 64'(r), 64'(16'hBEEF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
